frame_buffer_axis: RTL and testbench

//  Parametrised AXI-Stream beat buffer between the MAC-side subordinate stream and the frame former.

---
 rtl/eth_helper_pkg.sv | 18 +
 rtl/frame_buffer_ram.sv | 24 ++
 rtl/frame_buffer_axis.sv | 142 ++++++++++++++
 tb/tb_frame_buffer_axis.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_helper_pkg.sv
// Shared AXI-Stream beat type and circular-pointer helper for the Ethernet datapath.
package eth_helper_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int KEEP_W      = AXIS_DATA_W / 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [KEEP_W-1:0]      keep;
    logic                   last;
  } axis_beat_t;

  // Pointers carry one wrap bit above the address, so they count modulo 2*depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) % (2 * depth);
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous read, no reset on the array.
module frame_buffer_ram
  import eth_helper_pkg::*;
#(
  parameter type beat_t = axis_beat_t,
  parameter int  DEPTH  = 64
) (
  input  logic                     ACLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  beat_t                    wr_beat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output beat_t                    rd_beat
);

  beat_t mem [DEPTH];

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_addr] <= wr_beat;
  end

  assign rd_beat = mem[rd_addr];

endmodule

// File: rtl/frame_buffer_axis.sv
// AXI-Stream beat buffer: circular RAM plus registered output, cut-through or store-and-forward.
module frame_buffer_axis
  import eth_helper_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter bit STORE_FORWARD = 1'b0,
  parameter int DEPTH         = 64,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [DATA_WIDTH-1:0]    S_AXIS_tdata,
  input  logic [DATA_WIDTH/8-1:0]  S_AXIS_tkeep,
  input  logic                     S_AXIS_tvalid,
  input  logic                     S_AXIS_tlast,
  output logic                     S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]    M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0]  M_AXIS_tkeep,
  output logic                     M_AXIS_tvalid,
  output logic                     M_AXIS_tlast,
  input  logic                     M_AXIS_tready,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [FRAME_CNT_W-1:0]   frame_count,
  output logic                     oversize
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int LVL_W = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
  } beat_t;

  if ((DATA_WIDTH % 8) != 0 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("frame_buffer_axis: DATA_WIDTH must be a multiple of 8, DEPTH a power of 2 >= 4");
  end

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level_q;
  logic [FRAME_CNT_W-1:0] fcnt_q;
  logic                   rdy_q, bypass_q, oversize_q;
  beat_t                  in_beat, ram_beat, nxt_beat, out_p1;
  logic                   vld_p1;

  logic full_w, can_load, release_ok, s_ready, wr_en, fast, ram_wr, ram_rd, rd_en;
  logic fc_inc, fc_dec, ovf_set, byp_clr;

  assign in_beat.data = S_AXIS_tdata;
  assign in_beat.keep = S_AXIS_tkeep;
  assign in_beat.last = S_AXIS_tlast;

  frame_buffer_ram #(
    .beat_t (beat_t),
    .DEPTH  (DEPTH)
  ) u_ram (
    .ACLK    (ACLK),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_beat (in_beat),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_beat (ram_beat)
  );

  always_comb begin
    full_w     = (level_q == LVL_W'(DEPTH));
    can_load   = !vld_p1 || M_AXIS_tready;
    release_ok = !STORE_FORWARD || (fcnt_q != '0) || bypass_q;
    // A full RAM still accepts when the output stage drains a beat in the same cycle.
    s_ready    = rdy_q && (!full_w || (can_load && release_ok));
    wr_en      = S_AXIS_tvalid && s_ready;
    // Empty RAM: the incoming beat goes straight to the output register.
    fast       = (level_q == '0) && wr_en && can_load && release_ok;
    ram_rd     = can_load && release_ok && (level_q != '0);
    ram_wr     = wr_en && !fast;
    rd_en      = ram_rd || fast;
    nxt_beat   = fast ? in_beat : ram_beat;
    fc_inc     = ram_wr && S_AXIS_tlast;
    fc_dec     = ram_rd && ram_beat.last;
    ovf_set    = STORE_FORWARD && full_w && (fcnt_q == '0) && !bypass_q;
    byp_clr    = bypass_q && rd_en && nxt_beat.last;
  end

  // Stage p0: pointers, occupancy, frame accounting and store-and-forward control
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      fcnt_q     <= '0;
      bypass_q   <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      oversize_q <= ovf_set;
      if (ram_wr) wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
      if (ram_rd) rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
      case ({ram_wr, ram_rd})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (fc_inc && !fc_dec && (fcnt_q != '1))
        fcnt_q <= fcnt_q + FRAME_CNT_W'(1);
      else if (fc_dec && !fc_inc && (fcnt_q != '0))
        fcnt_q <= fcnt_q - FRAME_CNT_W'(1);
      if (ovf_set)      bypass_q <= 1'b1;
      else if (byp_clr) bypass_q <= 1'b0;
    end
  end

  // Stage p1: registered output beat, held until the downstream takes it
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (rd_en) begin
      out_p1 <= nxt_beat;
      vld_p1 <= 1'b1;
    end else if (M_AXIS_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign S_AXIS_tready = s_ready;
  assign M_AXIS_tdata  = out_p1.data;
  assign M_AXIS_tkeep  = out_p1.keep;
  assign M_AXIS_tlast  = out_p1.last;
  assign M_AXIS_tvalid = vld_p1;
  assign empty         = (level_q == '0) && !vld_p1;
  assign full          = full_w;
  assign level         = level_q;
  assign frame_count   = fcnt_q;
  assign oversize      = oversize_q;

endmodule

// File: tb/tb_frame_buffer_axis.sv
// Bench for frame_buffer_axis: one cut-through and one store-and-forward instance, FIFO scoreboard.
module tb_frame_buffer_axis;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int DEPTH = 64;
  localparam int BW = DW + KW + 1;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          sel = 1'b0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;

  logic          ct_sv, ct_sr, ct_mv, ct_ml, ct_mr, ct_empty, ct_full, ct_ovr;
  logic [DW-1:0] ct_md;
  logic [KW-1:0] ct_mk;
  logic [6:0]    ct_level;
  logic [7:0]    ct_fc;
  logic          sf_sv, sf_sr, sf_mv, sf_ml, sf_mr, sf_empty, sf_full, sf_ovr;
  logic [DW-1:0] sf_md;
  logic [KW-1:0] sf_mk;
  logic [6:0]    sf_level;
  logic [7:0]    sf_fc;

  assign ct_sv = s_tvalid & !sel;
  assign sf_sv = s_tvalid & sel;
  assign ct_mr = sel ? 1'b1 : m_tready;
  assign sf_mr = sel ? m_tready : 1'b1;

  logic cur_sr, cur_empty;
  assign cur_sr    = sel ? sf_sr : ct_sr;
  assign cur_empty = sel ? sf_empty : ct_empty;

  frame_buffer_axis #(.DATA_WIDTH(DW), .STORE_FORWARD(1'b0), .DEPTH(DEPTH), .FRAME_CNT_W(8)) dut_ct (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tvalid(ct_sv), .S_AXIS_tlast(s_tlast),
    .S_AXIS_tready(ct_sr),
    .M_AXIS_tdata(ct_md), .M_AXIS_tkeep(ct_mk), .M_AXIS_tvalid(ct_mv), .M_AXIS_tlast(ct_ml),
    .M_AXIS_tready(ct_mr),
    .empty(ct_empty), .full(ct_full), .level(ct_level), .frame_count(ct_fc), .oversize(ct_ovr)
  );

  frame_buffer_axis #(.DATA_WIDTH(DW), .STORE_FORWARD(1'b1), .DEPTH(DEPTH), .FRAME_CNT_W(8)) dut_sf (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tvalid(sf_sv), .S_AXIS_tlast(s_tlast),
    .S_AXIS_tready(sf_sr),
    .M_AXIS_tdata(sf_md), .M_AXIS_tkeep(sf_mk), .M_AXIS_tvalid(sf_mv), .M_AXIS_tlast(sf_ml),
    .M_AXIS_tready(sf_mr),
    .empty(sf_empty), .full(sf_full), .level(sf_level), .frame_count(sf_fc), .oversize(sf_ovr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted beat queued in order; a beat is owed until the consumer takes it.
  logic [BW-1:0] exp_q [2][$];
  logic          hold_v [2];
  logic [BW-1:0] hold_b [2];
  int            pops [2];
  logic          ovr_flag = 1'b0;
  int            ovr_pulses = 0;
  int            ovr_level = 0;

  function automatic logic sf_has_last();
    foreach (exp_q[1][i]) if (exp_q[1][i][0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mon_step(input int d, input logic sv, input logic sr, input logic [BW-1:0] sb,
                          input logic mv, input logic mr, input logic [BW-1:0] mb, input logic emp);
    logic [BW-1:0] e;
    chk($sformatf("empty_flag%0d", d), emp, exp_q[d].size() == 0);
    if (hold_v[d]) chk($sformatf("axis_hold%0d", d), {mv, mb}, {1'b1, hold_b[d]});
    hold_v[d] = mv & !mr;
    hold_b[d] = mb;
    if (mv && mr) begin
      if (exp_q[d].size() == 0) begin
        chk($sformatf("spurious_beat%0d", d), mb, 0);
        chk($sformatf("spurious_valid%0d", d), mv, 0);
      end else begin
        e = exp_q[d].pop_front();
        chk($sformatf("beat%0d", d), mb, e);
        pops[d]++;
        if (d == 1 && e[0]) ovr_flag = 1'b0;
      end
    end
    if (sv && sr) exp_q[d].push_back(sb);
  endtask

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      for (int d = 0; d < 2; d++) begin
        exp_q[d].delete();
        hold_v[d] = 1'b0;
      end
      ovr_flag = 1'b0;
    end else begin
      if (sf_ovr) begin
        ovr_flag = 1'b1;
        ovr_pulses++;
        ovr_level = int'(sf_level);
      end
      if (sf_mv) chk("sf_release_rule", sf_has_last() | ovr_flag, 1);
      mon_step(0, ct_sv, ct_sr, {s_tdata, s_tkeep, s_tlast}, ct_mv, ct_mr, {ct_md, ct_mk, ct_ml}, ct_empty);
      mon_step(1, sf_sv, sf_sr, {s_tdata, s_tkeep, s_tlast}, sf_mv, sf_mr, {sf_md, sf_mk, sf_ml}, sf_empty);
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    @(negedge ACLK);
    while (!cur_sr && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 300) chk("send_timeout", 0, 1);
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    @(negedge ACLK);
    while (!cur_empty && n < 400) begin
      @(negedge ACLK);
      n++;
    end
    chk(tag, cur_empty, 1);
    tick();
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] t1 [3];
    int n, p0, busy, beats_left;
    logic acc;
    hold_v[0] = 1'b0; hold_v[1] = 1'b0; pops[0] = 0; pops[1] = 0;

    // Reset state
    #12;
    chk("rst_mvalid", ct_mv, 0);
    chk("rst_mdata", {ct_md, ct_mk, ct_ml}, 0);
    chk("rst_empty", ct_empty, 1);
    chk("rst_full", ct_full, 0);
    chk("rst_level", ct_level, 0);
    chk("rst_fcnt", ct_fc, 0);
    chk("rst_oversize", ct_ovr, 0);
    chk("rst_sready_ct", ct_sr, 0);
    chk("rst_sready_sf", sf_sr, 0);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    tick();
    @(negedge ACLK);
    chk("sready_after_rst", ct_sr, 1);
    tick();

    // Cut-through: three back-to-back beats, one-cycle latency
    sel = 1'b0; m_tready = 1'b1;
    t1[0] = 64'h11; t1[1] = 64'h22; t1[2] = 64'h33;
    for (int i = 0; i < 3; i++) begin
      s_tdata = t1[i]; s_tkeep = 8'hFF; s_tlast = (i == 2); s_tvalid = 1'b1;
      @(negedge ACLK);
      chk("ct_sready", ct_sr, 1);
      if (i > 0) chk("ct_latency", {ct_mv, ct_md, ct_ml}, {1'b1, t1[i-1], 1'b0});
      tick();
    end
    s_tvalid = 1'b0;
    @(negedge ACLK);
    chk("ct_last_beat", {ct_mv, ct_md, ct_ml}, {1'b1, 64'h33, 1'b1});
    tick();
    @(negedge ACLK);
    chk("ct_idle_valid", ct_mv, 0);
    chk("ct_idle_empty", ct_empty, 1);
    tick();

    // Fill with consumer stalled, then read and write together while full
    m_tready = 1'b0; n = 0;
    s_tvalid = 1'b1; s_tdata = rnd64(); s_tkeep = 8'($urandom); s_tlast = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge ACLK);
      if (!ct_sr) break;
      n++;
      tick();
      s_tdata = rnd64(); s_tkeep = 8'($urandom);
    end
    chk("fill_count", n, DEPTH + 1);
    chk("fill_full", ct_full, 1);
    chk("fill_level", ct_level, DEPTH);
    chk("fill_sready", ct_sr, 0);
    tick();
    m_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      chk("rw_full_level", ct_level, DEPTH);
      chk("rw_full_sready", ct_sr, 1);
      tick();
      s_tdata = rnd64(); s_tkeep = 8'($urandom); s_tlast = (c == 9);
    end
    s_tvalid = 1'b0;
    wait_empty("drain_empty");
    chk("drain_level", ct_level, 0);

    // Store-and-forward: output withheld until tlast is stored
    sel = 1'b1; m_tready = 1'b1;
    tick();
    p0 = pops[1];
    for (int i = 0; i < 4; i++) send(rnd64(), 8'hFF, 1'b0);
    busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      if (sf_mv) busy++;
    end
    chk("sf_withheld", busy, 0);
    tick();
    send(rnd64(), 8'h0F, 1'b1);
    @(negedge ACLK);
    chk("sf_fcnt_one", sf_fc, 1);
    chk("sf_not_yet", sf_mv, 0);
    repeat (8) @(negedge ACLK);
    chk("sf_fcnt_zero", sf_fc, 0);
    chk("sf_empty", sf_empty, 1);
    chk("sf_beats_out", pops[1] - p0, 5);
    tick();

    // Store-and-forward oversize frame
    ovr_pulses = 0; p0 = pops[1];
    for (int i = 0; i < 70; i++) send(rnd64(), 8'($urandom), i == 69);
    wait_empty("ovr_empty");
    chk("ovr_pulses", ovr_pulses, 1);
    chk("ovr_level", ovr_level, DEPTH);
    chk("ovr_beats_out", pops[1] - p0, 70);
    send(rnd64(), 8'hFF, 1'b0);
    send(rnd64(), 8'hFF, 1'b0);
    busy = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      if (sf_mv) busy++;
    end
    chk("ovr_latch_cleared", busy, 0);
    tick();
    send(rnd64(), 8'hFF, 1'b1);
    wait_empty("ovr_next_empty");

    // Reset in the middle of a frame
    sel = 1'b0; m_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(rnd64(), 8'hFF, 1'b0);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_mvalid", ct_mv, 0);
    chk("mid_rst_empty", ct_empty, 1);
    chk("mid_rst_level", ct_level, 0);
    tick(); tick();
    ARESETN = 1'b1; m_tready = 1'b1;
    tick(); tick();
    @(negedge ACLK);
    chk("post_rst_sready", ct_sr, 1);
    chk("post_rst_empty", ct_empty, 1);
    tick();
    p0 = pops[0];
    for (int i = 0; i < 3; i++) send(rnd64(), 8'($urandom), i == 2);
    wait_empty("post_rst_drain");
    chk("post_rst_beats", pops[0] - p0, 3);

    // Randomized traffic and back-pressure on both instances
    for (int p = 0; p < 2; p++) begin
      sel = p[0]; beats_left = 0; s_tvalid = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge ACLK);
        acc = s_tvalid & cur_sr;
        tick();
        if (acc) beats_left--;
        if (!s_tvalid || acc) begin
          if (beats_left == 0) beats_left = $urandom_range(1, 12);
          s_tvalid = ($urandom_range(0, 2) != 0);
          s_tdata = rnd64(); s_tkeep = 8'($urandom); s_tlast = (beats_left == 1);
        end
        m_tready = ($urandom_range(0, 3) != 0);
      end
      m_tready = 1'b1;
      n = 0;
      while (s_tvalid && n < 300) begin
        @(negedge ACLK);
        acc = cur_sr;
        tick();
        n++;
        if (acc) begin
          beats_left--;
          s_tvalid = 1'b0;
        end
      end
      while (beats_left > 0) begin
        send(rnd64(), 8'($urandom), beats_left == 1);
        beats_left--;
      end
      wait_empty($sformatf("rand_drain%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
